// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multicycle RV32 core.
// Sequences FETCH..WB over the shared ALU datapath and drives every select
// and write enable. Build option BRANCH_BNE_EN adds bne (funct3=001) to the
// branch state, with pc_write = ~zero for that encoding.
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [1:0]         alu_sel,
  output logic               alu_cin,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_EXECI    = STATE_W'(8),
    S_JAL      = STATE_W'(9),
    S_BEQ      = STATE_W'(10)
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  state_e state_q, state_d;

  // Ungated enables; the write enables are masked by rst_n at the ports.
  logic pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  logic       alu_f3_ok, br_f3_ok, br_taken;
  logic [1:0] f_sel;
  logic       f_cin;

  // Operand-class legality and the funct3 -> ALU control mapping.
  always_comb begin
    alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);
`ifdef BRANCH_BNE_EN
    br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
    br_taken  = funct3[0] ? ~zero : zero;
`else
    br_f3_ok  = (funct3 == 3'b000);
    br_taken  = zero;
`endif
    f_sel = 2'b00;
    f_cin = 1'b0;
    case (funct3)
      3'b010:  begin f_sel = 2'b01; f_cin = 1'b1; end
      3'b110:  f_sel = 2'b10;
      3'b111:  f_sel = 2'b11;
      default: begin f_sel = 2'b00; f_cin = 1'b0; end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore decode (pc_write also uses zero in the branch state).
  always_comb begin
    state_d       = state_q;
    pc_write_c    = 1'b0;
    adr_src       = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_sel       = 2'b00;
    alu_cin       = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures OldPC + imm, the branch/jump target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_FETCH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         if (alu_f3_ok) state_d = S_EXECR; else illegal_instr = 1'b1;
          OP_I:         if (alu_f3_ok) state_d = S_EXECI; else illegal_instr = 1'b1;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        if (br_f3_ok) state_d = S_BEQ; else illegal_instr = 1'b1;
          default:      illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_sel   = f_sel;
        alu_cin   = (funct3 == 3'b000) ? funct7b5 : f_cin;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        // No subi: funct3=000 is always an add here.
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_sel   = f_sel;
        alu_cin   = f_cin;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC <= target from ALUOut while the ALU forms OldPC+4 for rd.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_cin    = 1'b1;
        pc_write_c = br_taken;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are held off for as long as reset is asserted.
  assign pc_write  = pc_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign state     = state_q;

endmodule
